// File: rtl/neuron_scheduler.sv
// rtl/neuron_scheduler.sv - time-multiplexed neuron scheduler around a shared combinational integrator
// Optional refractory counters are enabled with NEURON_SCHED_REFRACTORY_EN.
module neuron_scheduler #(
  parameter int          N            = 32,
  parameter int          NUM_NEURONS  = 8,
  parameter logic [N-1:0] V_INIT      = 32'hFFBF0000,
  parameter logic [N-1:0] W_INIT      = 32'hFFF10000,
  parameter int          REFRAC_STEPS = 2,
  localparam int         IW           = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  output logic [IW-1:0] i_idx,
  input  logic [N-1:0]  i_data,
  output logic          int_en,
  output logic [N-1:0]  int_I,
  output logic [N-1:0]  int_v_old,
  output logic [N-1:0]  int_w_old,
  input  logic [N-1:0]  int_v_new,
  input  logic [N-1:0]  int_w_new,
  input  logic          int_fire,
  output logic          spk_valid,
  output logic [IW-1:0] spk_idx,
  input  logic          spk_ready,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_EMIT, S_DONE} state_e;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURONS - 1);

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] spk_idx_q;
  logic          int_en_q;
  logic          spk_valid_q;
  logic          busy_q;
  logic          done_q;
  logic          overrun_q;
  logic [N-1:0]  v_q [NUM_NEURONS];
  logic [N-1:0]  w_q [NUM_NEURONS];

  logic          wb_en;
  logic          fire_ok;
  logic          is_last;

`ifdef NEURON_SCHED_REFRACTORY_EN
  localparam int CW = (REFRAC_STEPS < 1) ? 1 : $clog2(REFRAC_STEPS + 1);
  logic [CW-1:0] refr_q [NUM_NEURONS];
`endif

  assign is_last = (idx_q == LAST_IDX);

  // A refractory neuron keeps its EVAL slot so timestep latency stays fixed.
  always_comb begin
    wb_en   = 1'b1;
    fire_ok = int_fire;
`ifdef NEURON_SCHED_REFRACTORY_EN
    wb_en   = (refr_q[idx_q] == '0);
    fire_ok = int_fire && wb_en;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      spk_idx_q   <= '0;
      int_en_q    <= 1'b0;
      spk_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_q[i] <= V_INIT;
        w_q[i] <= W_INIT;
`ifdef NEURON_SCHED_REFRACTORY_EN
        refr_q[i] <= '0;
`endif
      end
    end else begin
      done_q <= 1'b0;
      if (tick && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (tick) begin
            state_q  <= S_EVAL;
            idx_q    <= '0;
            int_en_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        S_EVAL: begin
          if (wb_en) begin
            v_q[idx_q] <= int_v_new;
            w_q[idx_q] <= int_w_new;
          end
`ifdef NEURON_SCHED_REFRACTORY_EN
          if (!wb_en) begin
            refr_q[idx_q] <= refr_q[idx_q] - CW'(1);
          end else if (int_fire) begin
            refr_q[idx_q] <= CW'(REFRAC_STEPS);
          end
`endif
          if (fire_ok) begin
            state_q     <= S_EMIT;
            spk_idx_q   <= idx_q;
            int_en_q    <= 1'b0;
            spk_valid_q <= 1'b1;
          end else if (is_last) begin
            state_q  <= S_DONE;
            int_en_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_EMIT: begin
          if (spk_ready) begin
            spk_valid_q <= 1'b0;
            if (is_last) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= S_EVAL;
              idx_q    <= idx_q + IW'(1);
              int_en_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          idx_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Operands are zeroed outside EVAL so nothing stale reaches the integrator.
  assign i_idx     = idx_q;
  assign int_en    = int_en_q;
  assign int_I     = int_en_q ? i_data     : '0;
  assign int_v_old = int_en_q ? v_q[idx_q] : '0;
  assign int_w_old = int_en_q ? w_q[idx_q] : '0;
  assign spk_valid = spk_valid_q;
  assign spk_idx   = spk_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule
